// File: rtl/tomasulo_fetch_unit.sv
// Fetch stage for the tomasulo core: walks the PC from START_PC up to END_PC,
// reads a 1-cycle synchronous instruction memory and buffers {instr, pc} for issue.
module tomasulo_fetch_unit #(
  parameter int PC_W     = 4,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int START_PC = 0,
  parameter int END_PC   = 6
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     imem_rd,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_data,
  output logic                     iss_valid,
  output logic [INSTR_W-1:0]       iss_instr,
  output logic [PC_W-1:0]          iss_pc,
  input  logic                     iss_ready,
  input  logic                     redir_valid,
  input  logic [PC_W-1:0]          redir_pc,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INSTR_W + PC_W;
  localparam logic [PC_W-1:0] START_V = PC_W'(START_PC);
  localparam logic [PC_W-1:0] END_V   = PC_W'(END_PC);
  localparam logic [CW-1:0]   DEPTH_V = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  r_tag;
  logic             r_inflight;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    w_head;

  logic w_active;
  logic w_flush;
  logic w_credit;
  logic w_rd;
  logic w_push;
  logic w_pop;

  assign w_active = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_flush  = redir_valid && w_active;
  // The in-flight read holds a slot, so a full queue can never be pushed.
  assign w_credit = (r_count + CW'(r_inflight)) < DEPTH_V;
  // No new read in a redirect cycle: its data would only be thrown away.
  assign w_rd     = (r_state == S_FETCH) && (r_pc != END_V) && w_credit && !redir_valid;
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_push   = r_inflight && !w_flush;
  assign w_pop    = iss_valid && iss_ready;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (w_flush) begin
      w_pc_next    = redir_pc;
      w_state_next = (redir_pc == END_V) ? S_DRAIN : S_FETCH;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_next = S_FETCH;
            w_pc_next    = START_V;
          end
        end
        S_FETCH: begin
          if (w_rd) w_pc_next = w_pc_inc;
          if ((w_rd && (w_pc_inc == END_V)) || (!w_rd && (r_pc == END_V)))
            w_state_next = S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_count == '0) && !r_inflight) w_state_next = S_DONE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= START_V;
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_inflight <= w_rd;
      if (w_rd) r_tag <= r_pc;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk1) begin
    if (w_push) r_mem[r_wr_ptr] <= {imem_data, r_tag};
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign iss_valid = (r_count != '0);
  assign iss_instr = iss_valid ? w_head[EW-1:PC_W] : '0;
  assign iss_pc    = iss_valid ? w_head[PC_W-1:0] : '0;
  assign imem_rd   = w_rd;
  assign imem_addr = w_rd ? r_pc : '0;
  assign busy      = w_active;
  assign done      = (r_state == S_DONE);
  assign q_count   = r_count;

endmodule

// File: doc/tomasulo_fetch_unit.md
Name: tomasulo_fetch_unit

Overview:
- Instruction fetch and queue stage that produces the PC stream and instruction words consumed by the tomasulo issue stage.
- Reads a synchronous instruction memory with 1-cycle latency and buffers words in a small FIFO.
- Presents instructions to issue with a valid/ready handshake.
- Supports redirect (flush and new PC) and a programmed end address for terminating a run.

Parameters:
- PC_W, 4, PC and instruction-memory address width.
- INSTR_W, 16, instruction word width.
- DEPTH, 4, fetch-queue entries (power of two, at least 2).
- START_PC, 0, PC loaded on start.
- END_PC, 6, first PC that is not fetched; fetch stops when pc equals END_PC.

Ports:
- clk1  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured in IDLE and DONE only.
- imem_rd  out  1  instruction-memory read strobe.
- imem_addr  out  PC_W  read address; equals pc when imem_rd=1.
- imem_data  in  INSTR_W  read data, valid the cycle after imem_rd.
- iss_valid  out  1  queue head valid.
- iss_instr  out  INSTR_W  queue head instruction.
- iss_pc  out  PC_W  PC of the queue head.
- iss_ready  in  1  issue stage accepts the head this cycle.
- redir_valid  in  1  flush and redirect request.
- redir_pc  in  PC_W  redirect target.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  high in DONE.
- q_count  out  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pc=START_PC; queue empty.
  - In-flight flag cleared.
  - imem_rd=0, iss_valid=0, busy=0, done=0, q_count=0, imem_addr=0.
- States: IDLE, FETCH, DRAIN, DONE.
  - IDLE --start--> FETCH with pc=START_PC.
  - DONE --start--> FETCH with pc=START_PC.
  - FETCH --(a fetch is issued at pc=END_PC-1, or pc==END_PC with no read)--> DRAIN.
  - DRAIN --(queue empty and nothing in flight)--> DONE.
- Fetch rule (FETCH only):
  - imem_rd=1 when pc!=END_PC and q_count + inflight < DEPTH.
  - On imem_rd, pc increments modulo 2^PC_W and the in-flight flag sets with the tag pc.
  - At most one read is outstanding at a time, because latency is 1 and the flag clears as data lands.
- Writeback: on the cycle after imem_rd, {imem_data, tagged pc} is written at the queue tail, unless the read was flushed.
- Issue:
  - iss_valid = (q_count != 0); iss_instr and iss_pc are driven from the head entry.
  - A transfer occurs when iss_valid and iss_ready are both high; the head then pops.
  - iss_ready while iss_valid=0 has no effect.
  - Head fields stay stable while iss_valid=1 and iss_ready=0.
- Simultaneous push and pop: q_count is unchanged. A full queue never receives a push, because of the credit check.
- Redirect (FETCH or DRAIN; ignored in IDLE and DONE):
  - A transfer in the same cycle still completes.
  - Next cycle: queue empty, in-flight data discarded, pc=redir_pc, state FETCH.
  - If redir_pc==END_PC, the next state is DRAIN and then DONE.
  - A redirect and start in the same cycle cannot coexist, since the states differ.
- Wrap-around: pc 2^PC_W-1 increments to 0. The END_PC comparison still applies.
- start while busy is ignored.
- Reset asserted mid-run returns all state to reset values immediately; data returning after reset is dropped.

Test Plan:
- Basic stream:
  - Stimulus: reset; start; iss_ready=1; imem returns 16'hA000+addr.
  - Required: imem_addr sequence 0..5; issued pcs 0..5 with instrs A000..A005 in order; first iss_valid 2 cycles after start is sampled.
  - Required: done=1 after the last transfer; no read at pc 6.
- Backpressure:
  - Stimulus: iss_ready=0 after start.
  - Required: q_count rises to 4 and then imem_rd stays 0; head remains pc 0.
  - Stimulus: release iss_ready.
  - Required: pcs 0..5 issue with none lost or duplicated.
- Redirect:
  - Stimulus: at the cycle pc 2 is issued, redir_valid=1 with redir_pc=4.
  - Required: the pc 2 transfer counts; queued pc 3 and the in-flight read are discarded; the next issued pcs are 4 and 5, then done.
- Wrap:
  - Stimulus: START_PC=14, END_PC=2.
  - Required: fetch addresses 14, 15, 0, 1, then DRAIN then DONE.
- Async reset:
  - Stimulus: pull rst_n low while q_count=3 and a read is in flight.
  - Required: all outputs go to reset values without a clock edge.
  - Required: after release, the queue stays empty until start.
- Restart:
  - Stimulus: start in DONE.
  - Required: done drops next cycle and pc 0 is refetched.
  - Required: start pulses during FETCH are ignored, with no pc reset.
